muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Multi-cycle MULT/MULTU/DIV/DIVU execution unit and sequencer for the EX stage of the MIPS pipeline.
- Accepts an operation after ALU decode has classified it. Holds the pipeline via stall_o while it runs, then delivers a 64-bit {HI,LO} result with a one-cycle done pulse for the HI/LO register write.
- Division is radix-2 restoring, one quotient bit per cycle. Multiplication uses a fixed-latency registered product.

Parameters:
- MUL_LATENCY, 2, cycles from acceptance edge to done_o for MULT/MULTU; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  EX-stage instruction is a mul/div op
- op_i  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- a_i  in  32  rs operand (dividend / multiplicand)
- b_i  in  32  rt operand (divisor / multiplier)
- flush_i  in  1  exception/flush; abandons any operation in progress
- stall_o  out  1  hold IF/ID/EX (combinational)
- busy_o  out  1  operation in progress (registered)
- done_o  out  1  one-cycle result-valid pulse
- hi_o  out  32  HI result (remainder / product[63:32])
- lo_o  out  32  LO result (quotient / product[31:0])
- div_by_zero_o  out  1  pulses with done_o when a DIV/DIVU had b_i==0

Behaviour:
- Reset (async, rst=1): state=IDLE; busy_o, done_o and div_by_zero_o are 0; hi_o and lo_o are 0. Reset mid-operation discards all work.
- States: IDLE, MUL, DIV_PREP, DIV_RUN, DIV_FIX, DONE.
- Acceptance: in IDLE, when start_i=1 and flush_i=0. op_i, a_i and b_i are latched on that edge (E0). Inputs are don't-care afterwards.
- IDLE->MUL (op 0x) or IDLE->DIV_PREP (op 1x).
- MUL:
  - Product is computed signed (MULT) or unsigned (MULTU), 64 bits.
  - The counter expires MUL_LATENCY edges after E0, then the state moves to DONE.
- DIV_PREP (1 cycle):
  - Capture absolute values for DIV; raw values for DIVU.
  - Quotient sign = a[31]^b[31] (DIV only). Remainder sign = a[31] (DIV only).
- DIV_RUN: exactly 32 iterations, one per cycle, 6-bit counter 0..31; moves to DIV_FIX after count 31.
- DIV_FIX (1 cycle): apply two's-complement sign correction.
- Div latency: done_o is high in the cycle after edge E0+34.
- Signed overflow 0x80000000 / -1 yields LO=0x80000000, HI=0. This falls out of the unsigned-magnitude path; no special case is added.
- Divide by zero (b=0):
  - Full 34-cycle latency retained.
  - Result HI=a_i, LO=0xFFFFFFFF, for both DIV and DIVU; no sign correction.
  - div_by_zero_o=1 with done_o.
- DONE (1 cycle):
  - done_o=1; hi_o/lo_o already hold the new result (registered on entry).
  - Then DONE->IDLE unconditionally. start_i is ignored here: the same instruction is leaving EX.
- hi_o/lo_o change only on entry to DONE and hold otherwise.
- busy_o=1 in MUL, DIV_PREP, DIV_RUN, DIV_FIX; 0 in IDLE and DONE.
- stall_o = (IDLE & start_i & ~flush_i) | busy_o. It is 0 in DONE, so the pipeline advances on the done cycle.
- flush_i:
  - In any busy state: next state IDLE, no done_o, hi_o/lo_o unchanged.
  - In IDLE: blocks acceptance.
  - In DONE: no effect, because the result is already committed (writeback gating belongs to the pipeline).
- Back-to-back: a new start_i in the IDLE cycle right after DONE is accepted normally, so the minimum spacing is 1 idle cycle.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, MUL_LATENCY=2 -> done_o in cycle after E0+2; HI=0xFFFFFFFF, LO=0xFFFFFFF1; stall_o high from start cycle until done cycle, low on done cycle.
- MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE.
- DIVU a=100, b=7 -> done_o exactly 34 edges after E0, HI=2, LO=14. DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU a=0x1234, b=0 -> HI=0x1234, LO=0xFFFFFFFF, div_by_zero_o=1 with done_o.
- Start DIV, assert flush_i for 1 cycle at iteration 10 -> IDLE next edge, busy_o/stall_o drop, no done_o, hi_o/lo_o keep prior values. A following MULT 6*7 yields LO=42, HI=0.
- Assert rst asynchronously mid-DIV_RUN (off clock edge) -> busy_o, stall_o, hi_o and lo_o go 0 immediately. Also hold start_i high through DONE -> no second operation launched.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Bundle between the EX-stage decode and the multiply/divide sequencer.
// Request/response: start_i is a request that is accepted only while the unit is idle and flush_i is low;
// stall_o is its not-ready, and done_o is a one-cycle result pulse with no back-pressure.
interface muldiv_ctrl_if;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        flush_i;
   logic        stall_o;
   logic        busy_o;
   logic        done_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        div_by_zero_o;
   logic [2:0]  state_dbg;

   modport master (
      output start_i, op_i, a_i, b_i, flush_i,
      input  stall_o, busy_o, done_o, hi_o, lo_o, div_by_zero_o, state_dbg
   );

   modport slave (
      input  start_i, op_i, a_i, b_i, flush_i,
      output stall_o, busy_o, done_o, hi_o, lo_o, div_by_zero_o, state_dbg
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer: fixed-latency registered multiply, radix-2 restoring divide
// with magnitude datapath and final sign fix-up. Result lands in hi_o/lo_o on entry to DONE.
module muldiv_ctrl #(
   parameter int MUL_LATENCY = 2
) (
   input logic         clk,
   input logic         rst,
   muldiv_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MUL      = 3'd1,
      DIV_PREP = 3'd2,
      DIV_RUN  = 3'd3,
      DIV_FIX  = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t      state, state_n;
   logic [1:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [5:0]  cnt;
   logic [31:0] rem_q, quo_q, dvs_q;
   logic        qneg_q, rneg_q;
   logic [31:0] hi_q, lo_q;
   logic        busy_q;
   logic        accept;
   logic        sgn;
   logic [63:0] mul_a, mul_b, prod;
   logic [32:0] shifted, diff;
   logic        fits;
   logic [31:0] rem_step, quo_step;

   assign accept = (state == IDLE) && bus.start_i && !bus.flush_i;
   assign sgn    = ~op_q[0];

   // One 64x64 multiply truncated to 64 bits serves both signednesses via operand extension.
   assign mul_a = sgn ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
   assign mul_b = sgn ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
   assign prod  = mul_a * mul_b;

   // The dividend shifts out of quo_q's MSB while quotient bits shift in at the LSB.
   assign shifted  = {rem_q, quo_q[31]};
   assign diff     = shifted - {1'b0, dvs_q};
   assign fits     = shifted >= {1'b0, dvs_q};
   assign rem_step = fits ? diff[31:0] : shifted[31:0];
   assign quo_step = {quo_q[30:0], fits};

   always_comb begin
      state_n = state;
      case (state)
         IDLE:     if (accept) state_n = bus.op_i[1] ? DIV_PREP : MUL;
         MUL:      if (bus.flush_i) state_n = IDLE;
                   else if (cnt == 6'(MUL_LATENCY - 1)) state_n = DONE;
         DIV_PREP: state_n = bus.flush_i ? IDLE : DIV_RUN;
         DIV_RUN:  if (bus.flush_i) state_n = IDLE;
                   else if (cnt == 6'd31) state_n = DIV_FIX;
         DIV_FIX:  state_n = bus.flush_i ? IDLE : DONE;
         DONE:     state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         busy_q <= 1'b0;
         op_q   <= 2'b0;
         a_q    <= 32'b0;
         b_q    <= 32'b0;
         cnt    <= 6'b0;
         rem_q  <= 32'b0;
         quo_q  <= 32'b0;
         dvs_q  <= 32'b0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         hi_q   <= 32'b0;
         lo_q   <= 32'b0;
      end else begin
         state  <= state_n;
         busy_q <= (state_n == MUL) || (state_n == DIV_PREP) ||
                   (state_n == DIV_RUN) || (state_n == DIV_FIX);
         case (state)
            IDLE: if (accept) begin
               op_q <= bus.op_i;
               a_q  <= bus.a_i;
               b_q  <= bus.b_i;
               cnt  <= 6'b0;
            end
            MUL: begin
               cnt <= cnt + 6'd1;
               if (state_n == DONE) {hi_q, lo_q} <= prod;
            end
            DIV_PREP: begin
               dvs_q  <= (sgn && b_q[31]) ? -b_q : b_q;
               quo_q  <= (sgn && a_q[31]) ? -a_q : a_q;
               rem_q  <= 32'b0;
               qneg_q <= sgn & (a_q[31] ^ b_q[31]);
               rneg_q <= sgn & a_q[31];
               cnt    <= 6'b0;
            end
            DIV_RUN: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               cnt   <= cnt + 6'd1;
            end
            DIV_FIX: if (state_n == DONE) begin
               // Divide by zero reports the raw dividend, bypassing sign correction.
               if (b_q == 32'b0) begin
                  hi_q <= a_q;
                  lo_q <= 32'hFFFF_FFFF;
               end else begin
                  hi_q <= rneg_q ? -rem_q : rem_q;
                  lo_q <= qneg_q ? -quo_q : quo_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy_o        = busy_q;
   assign bus.stall_o       = accept | busy_q;
   assign bus.done_o        = (state == DONE);
   assign bus.div_by_zero_o = (state == DONE) && op_q[1] && (b_q == 32'b0);
   assign bus.hi_o          = hi_q;
   assign bus.lo_o          = lo_q;
   assign bus.state_dbg     = state;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases, flush/reset/hold-start scenarios and
// randomized operations checked against an arithmetic reference model.
module tb_muldiv_ctrl;
   localparam int MUL_LATENCY = 2;
   localparam int DIV_LATENCY = 34;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   muldiv_ctrl_if bus ();

   muldiv_ctrl #(.MUL_LATENCY(MUL_LATENCY)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: MIPS semantics with plain 64-bit arithmetic, truncating division.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         2'b00: return 64'(sa * sb);
         2'b01: return ua * ub;
         default: begin
            if (b == 32'b0) return {a, 32'hFFFF_FFFF};
            if (op == 2'b10) begin
               q = sa / sb;
               r = sa % sb;
               return {r[31:0], q[31:0]};
            end
            return {a % b, a / b};
         end
      endcase
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input bit hold, output logic [63:0] res);
      int edges;
      int lat;
      bit stall_ok;
      logic [63:0] exp;
      exp = model(op, a, b);
      lat = op[1] ? DIV_LATENCY : MUL_LATENCY;
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = op;
      bus.a_i     = a;
      bus.b_i     = b;
      #1 check({tag, "_stall_req"}, 64'(bus.stall_o), 64'd1);
      @(posedge clk);
      #1;
      if (!hold) begin
         bus.start_i = 1'b0;
         bus.op_i    = 2'($urandom_range(0, 3));
         bus.a_i     = $urandom;
         bus.b_i     = $urandom;
      end
      edges    = 0;
      stall_ok = 1'b1;
      while (!bus.done_o && edges < 100) begin
         if (!bus.stall_o || !bus.busy_o) stall_ok = 1'b0;
         @(posedge clk);
         #1;
         edges++;
      end
      check({tag, "_latency"}, 64'(edges), 64'(lat));
      check({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
      check({tag, "_done_stall"}, 64'({bus.stall_o, bus.busy_o}), 64'd0);
      check({tag, "_result"}, {bus.hi_o, bus.lo_o}, exp);
      check({tag, "_dbz"}, 64'(bus.div_by_zero_o), 64'(op[1] && b == 32'b0));
      res = {bus.hi_o, bus.lo_o};
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, 64'(bus.done_o), 64'd0);
      if (hold) begin
         bus.start_i = 1'b0;
         @(posedge clk);
         #1;
         check({tag, "_no_relaunch"}, 64'({bus.busy_o, bus.state_dbg}), 64'd0);
      end
   endtask

   logic [63:0] res;
   logic [63:0] prev;
   int          dones;

   initial begin
      checks      = 0;
      failures    = 0;
      rst         = 1'b1;
      bus.start_i = 1'b0;
      bus.op_i    = 2'b0;
      bus.a_i     = 32'b0;
      bus.b_i     = 32'b0;
      bus.flush_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {bus.hi_o, bus.lo_o}, 64'd0);
      check("reset_flags", 64'({bus.busy_o, bus.done_o, bus.div_by_zero_o, bus.stall_o}), 64'd0);
      check("reset_state", 64'(bus.state_dbg), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, "mult_neg", 1'b0, res);
      check("mult_neg_const", res, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(2'b01, 32'hFFFF_FFFF, 32'd2, "multu", 1'b0, res);
      check("multu_const", res, 64'h0000_0001_FFFF_FFFE);
      run_op(2'b11, 32'd100, 32'd7, "divu", 1'b0, res);
      check("divu_const", res, {32'd2, 32'd14});
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b0, res);
      check("div_neg_const", res, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0, res);
      check("div_ovf_const", res, 64'h0000_0000_8000_0000);
      run_op(2'b11, 32'h0000_1234, 32'd0, "divu_zero", 1'b0, res);
      check("divu_zero_const", res, 64'h0000_1234_FFFF_FFFF);
      run_op(2'b10, 32'hFFFF_FF00, 32'd0, "div_zero", 1'b0, res);
      check("div_zero_const", res, 64'hFFFF_FF00_FFFF_FFFF);

      // Flush at divide iteration 10.
      prev = {bus.hi_o, bus.lo_o};
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = 2'b10;
      bus.a_i     = 32'd12345;
      bus.b_i     = 32'd17;
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("flush_in_run", 64'(bus.state_dbg), 64'd3);
      bus.flush_i = 1'b1;
      @(posedge clk);
      #1 bus.flush_i = 1'b0;
      check("flush_idle", 64'({bus.busy_o, bus.stall_o, bus.done_o}), 64'd0);
      check("flush_hold_result", {bus.hi_o, bus.lo_o}, prev);
      dones = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (bus.done_o) dones++;
      end
      check("flush_no_done", 64'(dones), 64'd0);
      run_op(2'b00, 32'd6, 32'd7, "mult_after_flush", 1'b0, res);
      check("mult_after_flush_const", res, 64'd42);

      // start_i held through DONE must not relaunch.
      run_op(2'b01, 32'd1000, 32'd3000, "hold_start", 1'b1, res);

      // Back-to-back and random traffic.
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  op;
         logic [31:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'b0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'h8000_0000;
            default: ;
         endcase
         run_op(op, a, b, $sformatf("rand%0d", i), 1'b0, res);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      // Asynchronous reset mid-divide.
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.op_i    = 2'b11;
      bus.a_i     = 32'hDEAD_BEEF;
      bus.b_i     = 32'd3;
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_flags", 64'({bus.busy_o, bus.stall_o, bus.done_o}), 64'd0);
      check("async_rst_result", {bus.hi_o, bus.lo_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "after_rst", 1'b0, res);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
